dmem_ctrl: RTL and testbench

//  Parametrised data memory with a valid/ready request port, byte/half/word loads and stores, and sign/zero-extension.
//  Has a fixed-latency pipelined response, a post-reset clear sequencer, and optional fault detection.

---
 rtl/dmem_pkg.sv | 37 +++
 rtl/dmem_load_align.sv | 25 ++
 rtl/dmem_ctrl.sv | 143 ++++++++++++++
 tb/tb_dmem_ctrl.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared types for the data memory controller: access sizes, clear FSM states,
// response payload and the byte-enable helper.
package dmem_pkg;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned LANES  = DATA_W / 8;

    typedef enum logic [1:0] {
        SZ_B = 2'd0,
        SZ_H = 2'd1,
        SZ_W = 2'd2,
        SZ_X = 2'd3
    } size_e;

    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } state_e;

    typedef struct packed {
        logic              valid;
        logic              err;
        logic [DATA_W-1:0] rdata;
    } rsp_t;

    // Byte enables for a store; offset is already size-aligned, SZ_X behaves as a word.
    function automatic logic [LANES-1:0] lane_mask(size_e size, logic [1:0] offset);
        logic [LANES-1:0] mask;
        case (size)
            SZ_B:    mask = 4'b0001 << offset;
            SZ_H:    mask = offset[1] ? 4'b1100 : 4'b0011;
            default: mask = 4'b1111;
        endcase
        return mask;
    endfunction

endpackage

// File: rtl/dmem_load_align.sv
// Load data alignment: shifts the addressed lane down and sign/zero-extends it.
module dmem_load_align
    import dmem_pkg::*;
(
    input  logic [DATA_W-1:0] word,
    input  logic [1:0]        offset,
    input  size_e             size,
    input  logic              zero_ext,
    output logic [DATA_W-1:0] rdata_c
);

    logic [DATA_W-1:0] shifted;

    always_comb begin
        shifted = word >> {offset, 3'b000};
        case (size)
            SZ_B:    rdata_c = zero_ext ? {24'h000000, shifted[7:0]}
                                        : {{24{shifted[7]}}, shifted[7:0]};
            SZ_H:    rdata_c = zero_ext ? {16'h0000, shifted[15:0]}
                                        : {{16{shifted[15]}}, shifted[15:0]};
            default: rdata_c = shifted;
        endcase
    end

endmodule

// File: rtl/dmem_ctrl.sv
// Data memory controller: word-array storage with post-reset clear, byte/half/word
// access and fixed-latency responses. Define DMEM_FAULT_EN to enable fault detection.
module dmem_ctrl
    import dmem_pkg::*;
#(
    parameter int unsigned DEPTH      = 64,
    parameter int unsigned ADDR_W     = 32,
    parameter int unsigned RD_LATENCY = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              init_done
);

    localparam int unsigned IDX_W = $clog2(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];

    state_e            state_q, state_d;
    logic [IDX_W-1:0]  clear_ptr_q, clear_ptr_d;
    size_e             size;
    logic [1:0]        offset;
    logic [IDX_W-1:0]  idx;
    logic              accept;
    logic              fault;
    logic [LANES-1:0]  be;
    logic [DATA_W-1:0] wdata_sh;
    logic [DATA_W-1:0] load_data;
    rsp_t              stage_c;
    rsp_t              pipe_q [RD_LATENCY];

    assign size   = size_e'(req_size);
    assign idx    = req_addr[IDX_W+1:2];
    assign accept = req_valid & req_ready;

    // Misaligned offsets are truncated to the access size.
    always_comb begin
        case (size)
            SZ_B:    offset = req_addr[1:0];
            SZ_H:    offset = {req_addr[1], 1'b0};
            default: offset = 2'b00;
        endcase
    end

`ifdef DMEM_FAULT_EN
    assign fault = (size == SZ_H && req_addr[0])
                 || (size == SZ_W && req_addr[1:0] != 2'b00)
                 || (size == SZ_X)
                 || (|(req_addr >> (IDX_W + 2)));
`else
    logic addr_unused;
    assign addr_unused = ^req_addr;
    assign fault       = 1'b0;
`endif

    assign be       = lane_mask(size, offset);
    assign wdata_sh = req_wdata << {offset, 3'b000};

    // Clear FSM: one word per cycle, then serve requests.
    always_comb begin
        state_d     = state_q;
        clear_ptr_d = clear_ptr_q;
        case (state_q)
            INIT: begin
                clear_ptr_d = clear_ptr_q + IDX_W'(1);
                if (clear_ptr_q == IDX_W'(DEPTH - 1)) begin
                    state_d = RUN;
                end
            end
            RUN: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= INIT;
            clear_ptr_q <= '0;
            req_ready   <= 1'b0;
            init_done   <= 1'b0;
        end else begin
            state_q     <= state_d;
            clear_ptr_q <= clear_ptr_d;
            req_ready   <= (state_d == RUN);
            init_done   <= (state_d == RUN);
        end
    end

    always_ff @(posedge clk) begin
        if (state_q == INIT) begin
            mem[clear_ptr_q] <= '0;
        end else if (accept && req_we && !fault) begin
            for (int b = 0; b < int'(LANES); b++) begin
                if (be[b]) begin
                    mem[idx][8*b +: 8] <= wdata_sh[8*b +: 8];
                end
            end
        end
    end

    dmem_load_align u_align (
        .word     (mem[idx]),
        .offset   (offset),
        .size     (size),
        .zero_ext (req_unsigned),
        .rdata_c  (load_data)
    );

    always_comb begin
        stage_c       = '0;
        stage_c.valid = accept;
        stage_c.err   = accept & fault;
        stage_c.rdata = (accept && !req_we && !fault) ? load_data : '0;
    end

    // Response delay line; reset drops anything in flight.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < int'(RD_LATENCY); i++) begin
                pipe_q[i] <= '0;
            end
        end else begin
            pipe_q[0] <= stage_c;
            for (int i = 1; i < int'(RD_LATENCY); i++) begin
                pipe_q[i] <= pipe_q[i-1];
            end
        end
    end

    assign rsp_valid = pipe_q[RD_LATENCY-1].valid;
    assign rsp_err   = pipe_q[RD_LATENCY-1].err;
    assign rsp_rdata = pipe_q[RD_LATENCY-1].rdata;

endmodule

// File: tb/tb_dmem_ctrl.sv
// Directed bench for dmem_ctrl: one instance at RD_LATENCY=1 and one at 3 share the
// request inputs. Expectations depend on whether DMEM_FAULT_EN is defined.
module tb_dmem_ctrl;

    localparam logic [1:0] SB = 2'd0;
    localparam logic [1:0] SH = 2'd1;
    localparam logic [1:0] SW = 2'd2;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_we = 1'b0;
    logic [1:0]  req_size = 2'd0;
    logic        req_unsigned = 1'b0;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;

    logic        req_ready, rsp_valid, rsp_err, init_done;
    logic [31:0] rsp_rdata;
    logic        r3_ready, r3_valid, r3_err, r3_init_done;
    logic [31:0] r3_rdata;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    dmem_ctrl #(.DEPTH(64), .ADDR_W(32), .RD_LATENCY(1)) u_dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_we(req_we), .req_size(req_size), .req_unsigned(req_unsigned),
        .req_addr(req_addr), .req_wdata(req_wdata), .rsp_valid(rsp_valid),
        .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .init_done(init_done)
    );

    dmem_ctrl #(.DEPTH(64), .ADDR_W(32), .RD_LATENCY(3)) u_dut3 (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(r3_ready),
        .req_we(req_we), .req_size(req_size), .req_unsigned(req_unsigned),
        .req_addr(req_addr), .req_wdata(req_wdata), .rsp_valid(r3_valid),
        .rsp_rdata(r3_rdata), .rsp_err(r3_err), .init_done(r3_init_done)
    );

    // One request on the latency-1 instance; returns the response seen one cycle later.
    task automatic access(input logic we, input logic [1:0] sz, input logic uns,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          output logic v, output logic e, output logic [31:0] d);
        @(negedge clk);
        req_valid = 1'b1; req_we = we; req_size = sz; req_unsigned = uns;
        req_addr = addr; req_wdata = wdata;
        @(negedge clk);
        req_valid = 1'b0;
        v = rsp_valid; e = rsp_err; d = rsp_rdata;
    endtask

    // Bounded wait for init_done, watching for early ready and stray responses.
    task automatic wait_init(output int cyc, output bit ready_early, output bit rsp_seen);
        cyc = 0; ready_early = 1'b0; rsp_seen = 1'b0;
        while (init_done !== 1'b1 && cyc < 200) begin
            @(negedge clk);
            cyc++;
            if (init_done !== 1'b1 && (req_ready !== 1'b0 || r3_ready !== 1'b0)) ready_early = 1'b1;
            if (rsp_valid !== 1'b0 || r3_valid !== 1'b0) rsp_seen = 1'b1;
        end
    endtask

    task automatic test_reset();
        int cyc; bit early, seen;
        logic v, e; logic [31:0] d;
        repeat (2) @(negedge clk);
        checks++; if (req_ready !== 1'b0) begin failures++; $display("FAIL reset_ready: got %b expected 0", req_ready); end
        checks++; if (rsp_valid !== 1'b0) begin failures++; $display("FAIL reset_rsp_valid: got %b expected 0", rsp_valid); end
        checks++; if (rsp_rdata !== 32'h0) begin failures++; $display("FAIL reset_rdata: got %h expected 0", rsp_rdata); end
        checks++; if (rsp_err !== 1'b0) begin failures++; $display("FAIL reset_err: got %b expected 0", rsp_err); end
        checks++; if (init_done !== 1'b0) begin failures++; $display("FAIL reset_init_done: got %b expected 0", init_done); end
        rst = 1'b1;
        wait_init(cyc, early, seen);
        checks++; if (cyc < 64 || cyc > 65) begin failures++; $display("FAIL init_cycles: got %0d expected 64..65", cyc); end
        checks++; if (early) begin failures++; $display("FAIL ready_during_init: got 1 expected 0"); end
        checks++; if (req_ready !== 1'b1) begin failures++; $display("FAIL ready_after_init: got %b expected 1", req_ready); end
        for (int w = 0; w < 64; w++) begin
            access(1'b0, SW, 1'b0, 32'(w * 4), 32'h0, v, e, d);
            checks++;
            if (v !== 1'b1 || e !== 1'b0 || d !== 32'h0) begin
                failures++;
                $display("FAIL clear_word%0d: got v=%b e=%b d=%h expected v=1 e=0 d=0", w, v, e, d);
            end
        end
    endtask

    task automatic test_extend();
        logic v, e; logic [31:0] d;
        access(1'b1, SW, 1'b0, 32'h10, 32'hDEADBEEF, v, e, d);
        checks++; if (v !== 1'b1 || e !== 1'b0 || d !== 32'h0) begin failures++; $display("FAIL sw_rsp: got v=%b e=%b d=%h expected v=1 e=0 d=0", v, e, d); end
        access(1'b0, SB, 1'b0, 32'h13, 32'h0, v, e, d);
        checks++; if (d !== 32'hFFFFFFDE) begin failures++; $display("FAIL lb_13: got %h expected ffffffde", d); end
        access(1'b0, SB, 1'b1, 32'h13, 32'h0, v, e, d);
        checks++; if (d !== 32'h000000DE) begin failures++; $display("FAIL lbu_13: got %h expected 000000de", d); end
        access(1'b0, SH, 1'b0, 32'h10, 32'h0, v, e, d);
        checks++; if (d !== 32'hFFFFBEEF) begin failures++; $display("FAIL lh_10: got %h expected ffffbeef", d); end
        access(1'b0, SH, 1'b1, 32'h12, 32'h0, v, e, d);
        checks++; if (d !== 32'h0000DEAD) begin failures++; $display("FAIL lhu_12: got %h expected 0000dead", d); end
        access(1'b0, SB, 1'b1, 32'h11, 32'h0, v, e, d);
        checks++; if (d !== 32'h000000BE) begin failures++; $display("FAIL lbu_11: got %h expected 000000be", d); end
    endtask

    task automatic test_byte_store();
        logic v, e; logic [31:0] d;
        access(1'b1, SW, 1'b0, 32'h20, 32'h11223344, v, e, d);
        access(1'b1, SB, 1'b0, 32'h21, 32'hFFFFFFAA, v, e, d);
        access(1'b0, SW, 1'b0, 32'h20, 32'h0, v, e, d);
        checks++; if (d !== 32'h1122AA44) begin failures++; $display("FAIL sb_merge: got %h expected 1122aa44", d); end
        access(1'b1, SH, 1'b0, 32'h22, 32'hFFFF5566, v, e, d);
        access(1'b0, SW, 1'b0, 32'h20, 32'h0, v, e, d);
        checks++; if (d !== 32'h5566AA44) begin failures++; $display("FAIL sh_merge: got %h expected 5566aa44", d); end
    endtask

    task automatic test_back_to_back();
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_size = SW; req_unsigned = 1'b0;
        req_addr = 32'h24; req_wdata = 32'hCAFEF00D;
        @(negedge clk);
        req_we = 1'b0;
        @(negedge clk);
        req_valid = 1'b0;
        checks++; if (rsp_valid !== 1'b1 || rsp_rdata !== 32'hCAFEF00D) begin
            failures++; $display("FAIL b2b_load: got v=%b d=%h expected v=1 d=cafef00d", rsp_valid, rsp_rdata);
        end
    endtask

    task automatic test_stream();
        logic [31:0] exp_d [8];
        int rsp_cnt = 0;
        bit exp_v;
        repeat (4) @(negedge clk);
        for (int k = 0; k < 8; k++) exp_d[k] = (k % 2 == 1) ? (32'hA0A00000 + 32'(k - 1)) : 32'h0;
        for (int t = 0; t < 12; t++) begin
            @(negedge clk);
            exp_v = (t >= 3 && t <= 10);
            checks++;
            if (r3_valid !== exp_v) begin failures++; $display("FAIL lat3_valid_t%0d: got %b expected %b", t, r3_valid, exp_v); end
            if (exp_v) begin
                checks++;
                if (r3_rdata !== exp_d[t-3] || r3_err !== 1'b0) begin
                    failures++; $display("FAIL lat3_data%0d: got d=%h e=%b expected d=%h e=0", t - 3, r3_rdata, r3_err, exp_d[t-3]);
                end
            end
            if (r3_valid === 1'b1) rsp_cnt++;
            if (t < 8) begin
                req_valid = 1'b1; req_we = (t % 2 == 0); req_size = SW; req_unsigned = 1'b0;
                req_addr = 32'h40 + 32'(4 * (t / 2)); req_wdata = 32'hA0A00000 + 32'(t);
            end else begin
                req_valid = 1'b0;
            end
        end
        checks++; if (rsp_cnt != 8) begin failures++; $display("FAIL lat3_count: got %0d expected 8", rsp_cnt); end
    endtask

    task automatic test_fault();
        logic v, e; logic [31:0] d;
        access(1'b1, SW, 1'b0, 32'h00, 32'h5A5A1234, v, e, d);
`ifdef DMEM_FAULT_EN
        access(1'b0, SW, 1'b0, 32'h02, 32'h0, v, e, d);
        checks++; if (v !== 1'b1 || e !== 1'b1 || d !== 32'h0) begin failures++; $display("FAIL flt_lw02: got v=%b e=%b d=%h expected v=1 e=1 d=0", v, e, d); end
        access(1'b1, SH, 1'b0, 32'h05, 32'h0000BEEF, v, e, d);
        checks++; if (v !== 1'b1 || e !== 1'b1 || d !== 32'h0) begin failures++; $display("FAIL flt_sh05: got v=%b e=%b d=%h expected v=1 e=1 d=0", v, e, d); end
        access(1'b0, SW, 1'b0, 32'h100, 32'h0, v, e, d);
        checks++; if (v !== 1'b1 || e !== 1'b1 || d !== 32'h0) begin failures++; $display("FAIL flt_lw100: got v=%b e=%b d=%h expected v=1 e=1 d=0", v, e, d); end
        access(1'b1, SW, 1'b0, 32'h100, 32'h12345678, v, e, d);
        checks++; if (e !== 1'b1) begin failures++; $display("FAIL flt_sw100: got e=%b expected 1", e); end
        access(1'b0, SW, 1'b0, 32'h04, 32'h0, v, e, d);
        checks++; if (e !== 1'b0 || d !== 32'h0) begin failures++; $display("FAIL flt_word1: got e=%b d=%h expected e=0 d=0", e, d); end
        access(1'b0, SW, 1'b0, 32'h00, 32'h0, v, e, d);
        checks++; if (e !== 1'b0 || d !== 32'h5A5A1234) begin failures++; $display("FAIL flt_word0: got e=%b d=%h expected e=0 d=5a5a1234", e, d); end
`else
        access(1'b0, SW, 1'b0, 32'h102, 32'h0, v, e, d);
        checks++; if (v !== 1'b1 || e !== 1'b0 || d !== 32'h5A5A1234) begin failures++; $display("FAIL wrap_lw102: got v=%b e=%b d=%h expected v=1 e=0 d=5a5a1234", v, e, d); end
        access(1'b1, SH, 1'b0, 32'h105, 32'h0000BEEF, v, e, d);
        checks++; if (e !== 1'b0) begin failures++; $display("FAIL wrap_sh105_err: got %b expected 0", e); end
        access(1'b0, SW, 1'b0, 32'h04, 32'h0, v, e, d);
        checks++; if (d !== 32'h0000BEEF) begin failures++; $display("FAIL wrap_word1: got %h expected 0000beef", d); end
`endif
    endtask

    task automatic test_reset_mid();
        int cyc; bit early, seen;
        logic v, e; logic [31:0] d;
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b0; req_size = SW; req_unsigned = 1'b0; req_addr = 32'h10;
        @(negedge clk);
        req_addr = 32'h20;
        @(negedge clk);
        req_valid = 1'b0;
        rst = 1'b0;
        #1;
        checks++; if (rsp_valid !== 1'b0 || r3_valid !== 1'b0) begin failures++; $display("FAIL mid_rst_drop: got %b/%b expected 0/0", rsp_valid, r3_valid); end
        repeat (2) @(negedge clk);
        rst = 1'b1;
        wait_init(cyc, early, seen);
        checks++; if (seen) begin failures++; $display("FAIL mid_rst_stray_rsp: got 1 expected 0"); end
        checks++; if (cyc < 64 || cyc > 65) begin failures++; $display("FAIL mid_rst_init_cycles: got %0d expected 64..65", cyc); end
        access(1'b0, SW, 1'b0, 32'h10, 32'h0, v, e, d);
        checks++; if (v !== 1'b1 || d !== 32'h0) begin failures++; $display("FAIL mid_rst_w10: got v=%b d=%h expected v=1 d=0", v, d); end
        access(1'b0, SW, 1'b0, 32'h20, 32'h0, v, e, d);
        checks++; if (d !== 32'h0) begin failures++; $display("FAIL mid_rst_w20: got %h expected 0", d); end
        access(1'b0, SW, 1'b0, 32'h00, 32'h0, v, e, d);
        checks++; if (d !== 32'h0) begin failures++; $display("FAIL mid_rst_w00: got %h expected 0", d); end
    endtask

    initial begin
        test_reset();
        test_extend();
        test_byte_store();
        test_back_to_back();
        test_stream();
        test_fault();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
